imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001: Parameter ADDR_W, default 11, instruction memory address width.
REQ-002: Parameter DATA_W, default 32, instruction word width.
REQ-003: Parameter MAX_LOCK, default 8, maximum number of consecutive debug grants under lock, range 1..255.
REQ-004: i_Clk  in  1  single clock; all state updates on rising edge.
REQ-005: i_Rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006: i_Fetch_Req  in  1  fetch requester wants a read this cycle.
REQ-007: iv_Fetch_Addr  in  ADDR_W  fetch read address.
REQ-008: o_Fetch_Gnt  out  1  fetch request accepted this cycle.
REQ-009: o_Fetch_Valid  out  1  ov_Fetch_Data holds a fetch response.
REQ-010: ov_Fetch_Data  out  DATA_W  fetch response word.
REQ-011: i_Dbg_Req  in  1  debug/loader requester wants a read this cycle.
REQ-012: i_Dbg_Lock  in  1  debug requests back-to-back ownership.
REQ-013: iv_Dbg_Addr  in  ADDR_W  debug read address.
REQ-014: o_Dbg_Gnt  out  1  debug request accepted this cycle.
REQ-015: o_Dbg_Valid  out  1  ov_Dbg_Data holds a debug response.
REQ-016: ov_Dbg_Data  out  DATA_W  debug response word.
REQ-017: ov_Mem_Address  out  ADDR_W  address to Instruction_Mem iv_Address.
REQ-018: iv_Mem_Data  in  DATA_W  Instruction_Mem ov_Data; word for the address sampled at edge N is valid throughout cycle N+1.

Function
REQ-019: Grants SHALL be combinational from the current requests and state; at most one of o_Fetch_Gnt/o_Dbg_Gnt is high per cycle; a grant is never issued without the matching request.
REQ-020: Granted address SHALL drive ov_Mem_Address combinationally; with no grant, ov_Mem_Address SHALL hold the last granted address (registered copy).
REQ-021: FSM states: RR (round-robin) and LOCKED.
REQ-022: RR, single requester: that requester is granted every cycle it requests.
REQ-023: RR, both requesting: grant goes to the requester not granted most recently (1-bit last-grant pointer, updated on every grant).
REQ-024: RR -> LOCKED when debug is granted with i_Dbg_Lock=1; lock counter loads 1.
REQ-025: LOCKED: debug has absolute priority while i_Dbg_Req=1 and i_Dbg_Lock=1; each debug grant increments the lock counter.
REQ-026: LOCKED: when the counter reaches MAX_LOCK and fetch is requesting, the next cycle grants fetch once, the counter clears, and the state stays LOCKED if i_Dbg_Lock=1; if fetch is not requesting, debug continues and the counter saturates at MAX_LOCK.
REQ-027: LOCKED -> RR when i_Dbg_Lock=0 or i_Dbg_Req=0 at an edge; the counter clears; that cycle's grant follows RR rules.
REQ-028: Response routing SHALL use a 2-bit registered tag {valid, owner}: exactly one cycle after a grant, the owner's Valid is high for one cycle and its Data equals iv_Mem_Data.
REQ-029: Back-to-back grants SHALL sustain one response per cycle, in grant order, with no bubbles.
REQ-030: ov_Fetch_Data/ov_Dbg_Data SHALL hold their last delivered word while the matching Valid is low.
REQ-031: Addresses are passed unmodified; 0 and 2^ADDR_W-1 (2047) are ordinary addresses with no wrap logic.
REQ-032: Changes to requests/addresses after a grant SHALL not affect the response already in flight.

Reset
REQ-033: i_Rst_n=0 SHALL immediately force: state RR, last-grant pointer = debug (so fetch wins the first conflict), lock counter 0, tag invalid, ov_Mem_Address 0, both Valid 0, both Data 0; grant outputs are held 0 during reset.
REQ-034: Reset mid-transaction SHALL discard the in-flight response: no Valid pulse after release for a grant issued before reset.
REQ-035: After i_Rst_n rises, the first rising edge SHALL accept grants normally.

Verification
REQ-036: Fetch alone, addresses 1..8 on consecutive cycles -> Gnt high each cycle, Valid high cycles 2..9, data = memory words 1..8 in order.
REQ-037: Both request every cycle, no lock, fetch 16 / debug 2040 -> grants alternate F,D,F,D; responses alternate to the correct port with 1-cycle latency.
REQ-038: Debug lock held 12 cycles, MAX_LOCK=8, fetch requesting -> 8 debug grants, 1 fetch grant, then debug grants resume.
REQ-039: Debug lock dropped mid-burst -> returns to RR at the next edge; the next conflict is resolved by the pointer.
REQ-040: Reset asserted in the cycle after a grant to address 2047 -> no Valid pulse; all outputs 0; first post-reset conflict granted to fetch.
REQ-041: Requests idle for 5 cycles after a grant to address 5 -> ov_Mem_Address holds 5 and ov_Fetch_Data holds the word last read.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port read arbiter in front of a single-port synchronous instruction memory.
// Round-robin between fetch and debug, with a bounded debug lock mode that still lets fetch in.
module imem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Fetch_Req,
  input  logic [ADDR_W-1:0] iv_Fetch_Addr,
  output logic              o_Fetch_Gnt,
  output logic              o_Fetch_Valid,
  output logic [DATA_W-1:0] ov_Fetch_Data,
  input  logic              i_Dbg_Req,
  input  logic              i_Dbg_Lock,
  input  logic [ADDR_W-1:0] iv_Dbg_Addr,
  output logic              o_Dbg_Gnt,
  output logic              o_Dbg_Valid,
  output logic [DATA_W-1:0] ov_Dbg_Data,
  output logic [ADDR_W-1:0] ov_Mem_Address,
  input  logic [DATA_W-1:0] iv_Mem_Data
);

  typedef enum logic {ST_RR = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_e              state_q, state_d;
  logic                last_dbg_q, last_dbg_d;
  logic [7:0]          lock_cnt_q, lock_cnt_d;
  logic                tag_vld_q, tag_vld_d;
  logic                tag_own_q, tag_own_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic                fetch_gnt, dbg_gnt;
  logic                rr_fetch, rr_dbg;

  always_comb begin
    fetch_gnt  = 1'b0;
    dbg_gnt    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    // Round-robin choice: the pointer names the side granted most recently.
    rr_fetch   = i_Fetch_Req & (~i_Dbg_Req | last_dbg_q);
    rr_dbg     = i_Dbg_Req & (~i_Fetch_Req | ~last_dbg_q);

    if (i_Rst_n) begin
      case (state_q)
        ST_RR: begin
          fetch_gnt = rr_fetch;
          dbg_gnt   = rr_dbg;
          if (rr_dbg && i_Dbg_Lock) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = 8'd1;
          end
        end
        ST_LOCKED: begin
          if (i_Dbg_Req && i_Dbg_Lock) begin
            // A full lock window yields exactly one slot to a waiting fetch.
            if (lock_cnt_q >= MAX_CNT && i_Fetch_Req) begin
              fetch_gnt  = 1'b1;
              lock_cnt_d = 8'd0;
            end else begin
              dbg_gnt    = 1'b1;
              lock_cnt_d = (lock_cnt_q >= MAX_CNT) ? MAX_CNT : lock_cnt_q + 8'd1;
            end
          end else begin
            fetch_gnt  = rr_fetch;
            dbg_gnt    = rr_dbg;
            state_d    = ST_RR;
            lock_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d    = ST_RR;
          lock_cnt_d = 8'd0;
        end
      endcase
    end

    last_dbg_d = dbg_gnt ? 1'b1 : (fetch_gnt ? 1'b0 : last_dbg_q);
    tag_vld_d  = fetch_gnt | dbg_gnt;
    tag_own_d  = dbg_gnt;
    addr_d     = dbg_gnt ? iv_Dbg_Addr : (fetch_gnt ? iv_Fetch_Addr : addr_q);

    // The memory word for last cycle's grant is on iv_Mem_Data now; capture it for holding.
    o_Fetch_Valid = tag_vld_q & ~tag_own_q;
    o_Dbg_Valid   = tag_vld_q & tag_own_q;
    ov_Fetch_Data = o_Fetch_Valid ? iv_Mem_Data : fetch_data_q;
    ov_Dbg_Data   = o_Dbg_Valid ? iv_Mem_Data : dbg_data_q;
    fetch_data_d  = ov_Fetch_Data;
    dbg_data_d    = ov_Dbg_Data;
  end

  assign o_Fetch_Gnt    = fetch_gnt;
  assign o_Dbg_Gnt      = dbg_gnt;
  assign ov_Mem_Address = addr_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_RR;
      last_dbg_q   <= 1'b1;
      lock_cnt_q   <= 8'd0;
      tag_vld_q    <= 1'b0;
      tag_own_q    <= 1'b0;
      addr_q       <= '0;
      fetch_data_q <= '0;
      dbg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      lock_cnt_q   <= lock_cnt_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
      addr_q       <= addr_d;
      fetch_data_q <= fetch_data_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

endmodule
